// File: rtl/mips_mem_pkg.sv
// Shared encodings and byte-lane helpers for the MEM-stage load/store path.
// Imported by the stage top and the load aligner.
package mips_mem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // op[1:0] carries the size; op[2] only selects zero extension.
    function automatic logic is_aligned(
        input logic [2:0] op,
        input logic [1:0] a
    );
        logic ok;
        ok = (a == 2'b00);
        if (op[1:0] == 2'b00)
            ok = 1'b1;
        else if (op[1:0] == 2'b01)
            ok = ~a[0];
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(
        input logic       store,
        input logic [2:0] op,
        input logic [1:0] a
    );
        logic [3:0] be;
        be = 4'b1111;
        if (store && op[1:0] == 2'b00)
            be = 4'b0001 << a;
        else if (store && op[1:0] == 2'b01)
            be = a[1] ? 4'b1100 : 4'b0011;
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(
        input logic [2:0]  op,
        input logic [31:0] d
    );
        logic [31:0] w;
        w = d;
        if (op[1:0] == 2'b00)
            w = {4{d[7:0]}};
        else if (op[1:0] == 2'b01)
            w = {2{d[15:0]}};
        return w;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and extends it.
// Purely combinational so a cache can reuse it.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{addr_lo, 3'b000} +: 8];
        h    = addr_lo[1] ? word[31:16] : word[15:0];
        data = word;
        unique case (1'b1)
            (op == MOP_B):  data = {{24{b[7]}}, b};
            (op == MOP_BU): data = {24'd0, b};
            (op == MOP_H):  data = {{16{h[15]}}, h};
            (op == MOP_HU): data = {16'd0, h};
            default:        data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: req/ack data bus master with lane steering,
// load extension, timeout abort and pipeline stall generation.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_MemOp,
    input  logic [31:0] MEM_ALU_res,
    input  logic [31:0] MEM_wdata,
    output logic [31:0] MEM_rdata,
    output logic        MEM_stall,
    output logic        MEM_adel,
    output logic        MEM_ades,
    output logic        MEM_buserr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           state_nx;
    logic             access;
    logic             aligned;
    logic             expired;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [1:0]       off_q;
    logic [31:0]      rdata_q;
    logic [31:0]      ld_data;
    logic             buserr_q;

    assign access     = MEM_MemRead | MEM_MemWrite;
    assign aligned    = is_aligned(MEM_MemOp, MEM_ALU_res[1:0]);
    assign expired    = (cnt == TO);
    assign MEM_rdata  = rdata_q;
    assign MEM_buserr = buserr_q;

    // Extraction uses the offset latched with the request.
    mem_load_align u_align (
        .word    (dmem_rdata),
        .addr_lo (off_q),
        .op      (op_q),
        .data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (access && aligned) state_nx = BUSY;
            BUSY: if (dmem_ack || expired) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        MEM_stall = 1'b0;
        MEM_adel  = 1'b0;
        MEM_ades  = 1'b0;
        unique case (state)
            IDLE: begin
                MEM_stall = access & aligned;
                MEM_adel  = MEM_MemRead & ~aligned;
                MEM_ades  = MEM_MemWrite & ~aligned;
            end
            BUSY:    MEM_stall = 1'b1;
            default: MEM_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            rdata_q    <= 32'd0;
            cnt        <= '0;
            op_q       <= 3'd0;
            off_q      <= 2'd0;
            buserr_q   <= 1'b0;
        end else begin
            buserr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (access && aligned) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_MemWrite;
                        dmem_addr  <= {MEM_ALU_res[31:2], 2'b00};
                        dmem_be    <= lane_be(MEM_MemWrite, MEM_MemOp,
                                              MEM_ALU_res[1:0]);
                        dmem_wdata <= MEM_MemWrite ?
                                      lane_wdata(MEM_MemOp, MEM_wdata) :
                                      32'd0;
                        cnt        <= '0;
                        op_q       <= MEM_MemOp;
                        off_q      <= MEM_ALU_res[1:0];
                    end else if (access) begin
                        rdata_q <= 32'd0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we)
                            rdata_q <= ld_data;
                    end else if (expired) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rdata_q  <= 32'd0;
                        buserr_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for the MEM-stage load/store unit,
// checked against a size/offset arithmetic reference model.
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [2:0]  MEM_MemOp;
    logic [31:0] MEM_ALU_res;
    logic [31:0] MEM_wdata;
    logic [31:0] MEM_rdata;
    logic        MEM_stall;
    logic        MEM_adel;
    logic        MEM_ades;
    logic        MEM_buserr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] exp_rdata;
    logic [2:0]  ops [5] = '{MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU};

    always #5 clk = ~clk;

    mem_access_stage #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemOp    (MEM_MemOp),
        .MEM_ALU_res  (MEM_ALU_res),
        .MEM_wdata    (MEM_wdata),
        .MEM_rdata    (MEM_rdata),
        .MEM_stall    (MEM_stall),
        .MEM_adel     (MEM_adel),
        .MEM_ades     (MEM_ades),
        .MEM_buserr   (MEM_buserr),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        if (op == MOP_W) return 4;
        if (op == MOP_H || op == MOP_HU) return 2;
        return 1;
    endfunction

    function automatic bit ref_aligned(
        input logic [2:0]  op,
        input logic [31:0] a
    );
        return (a % nbytes(op)) == 0;
    endfunction

    function automatic logic [31:0] ref_be(
        input bit          ld,
        input logic [2:0]  op,
        input logic [31:0] a
    );
        if (ld || nbytes(op) == 4) return 32'd15;
        if (nbytes(op) == 1) return 32'd1 << (a % 4);
        return ((a % 4) >= 2) ? 32'd12 : 32'd3;
    endfunction

    function automatic logic [31:0] ref_wdata(
        input logic [2:0]  op,
        input logic [31:0] w
    );
        if (nbytes(op) == 1) return (w & 32'hFF) * 32'h01010101;
        if (nbytes(op) == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(
        input logic [31:0] w,
        input logic [31:0] a,
        input logic [2:0]  op
    );
        int unsigned bv;
        int unsigned hv;
        bv = (w >> (8 * (a % 4))) & 32'hFF;
        hv = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            MOP_B:   return (bv >= 128) ? bv - 256 : bv;
            MOP_BU:  return bv;
            MOP_H:   return (hv >= 32768) ? hv - 65536 : hv;
            MOP_HU:  return hv;
            default: return w;
        endcase
    endfunction

    task automatic go_idle();
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
    endtask

    // One instruction through MEM; dly = BUSY cycle of the ack, > T = none.
    task automatic do_access(
        input bit          ld,
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rw,
        input int          dly
    );
        bit acked;
        acked = 1'b0;
        @(posedge clk); #1;
        MEM_MemRead  = ld;
        MEM_MemWrite = !ld;
        MEM_MemOp    = op;
        MEM_ALU_res  = a;
        MEM_wdata    = wd;
        @(negedge clk);
        if (!ref_aligned(op, a)) begin
            chk("stall_mis", MEM_stall, 0);
            chk(ld ? "adel" : "ades", ld ? MEM_adel : MEM_ades, 1);
            chk("exc_other", ld ? MEM_ades : MEM_adel, 0);
            chk("req_mis", dmem_req, 0);
            @(posedge clk); #1;
            go_idle();
            exp_rdata = 32'd0;
            @(negedge clk);
            chk("rdata_mis", MEM_rdata, exp_rdata);
            chk("exc_pulse", MEM_adel | MEM_ades, 0);
            chk("req_mis2", dmem_req, 0);
            return;
        end
        chk("stall_issue", MEM_stall, 1);
        chk("exc_none", MEM_adel | MEM_ades, 0);
        for (int k = 0; k <= T; k++) begin
            @(posedge clk); #1;
            dmem_ack   = (k == dly);
            dmem_rdata = dmem_ack ? rw : $urandom;
            @(negedge clk);
            chk("req_busy", dmem_req, 1);
            chk("stall_busy", MEM_stall, 1);
            if (k == 0) begin
                chk("addr", dmem_addr, a & ~32'd3);
                chk("we", dmem_we, !ld);
                chk("be", dmem_be, ref_be(ld, op, a));
                if (!ld) chk("wdata", dmem_wdata, ref_wdata(op, wd));
            end
            if (k == dly) begin
                acked = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (!acked)
            exp_rdata = 32'd0;
        else if (ld)
            exp_rdata = ref_load(rw, a, op);
        @(negedge clk);
        chk("stall_done", MEM_stall, 0);
        chk("req_done", dmem_req, 0);
        chk("we_done", dmem_we, 0);
        chk("rdata_done", MEM_rdata, exp_rdata);
        chk("buserr_done", MEM_buserr, !acked);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        chk("buserr_idle", MEM_buserr, 0);
        chk("stall_idle", MEM_stall, 0);
        chk("rdata_idle", MEM_rdata, exp_rdata);
    endtask

    initial begin
        bit          ld;
        logic [2:0]  op;
        rst_n        = 1'b0;
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        MEM_MemOp    = MOP_W;
        MEM_ALU_res  = 32'd0;
        MEM_wdata    = 32'd0;
        dmem_rdata   = 32'd0;
        dmem_ack     = 1'b0;
        exp_rdata    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_rdata", MEM_rdata, 0);
        chk("rst_stall", MEM_stall, 0);
        chk("rst_buserr", MEM_buserr, 0);
        rst_n = 1'b1;

        do_access(1, MOP_W, 32'h100, 32'd0, 32'hDEADBEEF, 0);
        chk("lw_value", MEM_rdata, 32'hDEADBEEF);
        do_access(1, MOP_B, 32'h103, 32'd0, 32'h80112233, 0);
        chk("lb_value", MEM_rdata, 32'hFFFFFF80);
        do_access(1, MOP_BU, 32'h103, 32'd0, 32'h80112233, 1);
        chk("lbu_value", MEM_rdata, 32'h00000080);
        do_access(0, MOP_H, 32'h202, 32'h0000ABCD, 32'd0, 0);
        chk("sh_keep", MEM_rdata, 32'h00000080);
        do_access(1, MOP_W, 32'h101, 32'd0, 32'd0, 0);
        do_access(0, MOP_W, 32'h102, 32'h5555AAAA, 32'd0, 0);
        do_access(1, MOP_H, 32'h106, 32'd0, 32'hC0DE7FFF, 2);
        do_access(1, MOP_W, 32'h300, 32'd0, 32'h12345678, T + 1);
        chk("timeout_rdata", MEM_rdata, 32'd0);

        // Reset in the middle of a BUSY access, then a stray ack.
        @(posedge clk); #1;
        MEM_MemRead = 1'b1;
        MEM_MemOp   = MOP_W;
        MEM_ALU_res = 32'h340;
        repeat (2) @(posedge clk);
        #2;
        chk("req_pre_rst", dmem_req, 1);
        rst_n = 1'b0;
        go_idle();
        #1;
        exp_rdata = 32'd0;
        chk("req_async_rst", dmem_req, 0);
        chk("stall_rst", MEM_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_stall", MEM_stall, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rdata", MEM_rdata, exp_rdata);
        do_access(1, MOP_W, 32'h400, 32'd0, 32'hCAFEF00D, 1);

        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom % 2);
            op = ld ? ops[$urandom % 5] : ops[$urandom % 3];
            do_access(ld, op, $urandom, $urandom, $urandom,
                      int'($urandom % (T + 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
